dp_ram_obi: RTL and testbench

- Parametrised dual-port RAM that replaces the single-port byte-enabled RAM in the verilator model.
- Port A serves instruction fetch; port B serves data load/store.
- Each port uses a req/gnt/rvalid handshake compatible with the core's LSU and prefetcher.
- Read latency is configurable, and same-word write collisions between the ports resolve deterministically.

---
 rtl/dp_ram_pkg.sv | 19 +
 rtl/dp_ram_obi_if.sv | 17 +
 rtl/dp_ram_rsp_pipe.sv | 35 +++
 rtl/dp_ram_obi.sv | 98 +++++++++
 tb/tb_dp_ram_obi.sv | 358 +++++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/dp_ram_pkg.sv
// Shared constants and helpers for the dual-port OBI RAM.
// LFSR_TAPS is used only when RAM_GNT_STALL_EN is defined.
package dp_ram_pkg;

  localparam int unsigned DEF_DATA_WIDTH = 32;
  localparam int unsigned BYTES_PER_WORD = DEF_DATA_WIDTH / 8;
  localparam int unsigned WORD_OFFS      = $clog2(BYTES_PER_WORD);

  // Fibonacci taps 16,14,13,11 (bit indices 15,13,12,10)
  localparam logic [15:0] LFSR_TAPS = 16'hB400;

  // Word index from a byte address; upper bits beyond the depth wrap silently
  function automatic logic [31:0] word_idx(input logic [63:0] addr,
                                           input int unsigned offs,
                                           input int unsigned num_words);
    return 32'((addr >> offs) & 64'(num_words - 1));
  endfunction

endpackage

// File: rtl/dp_ram_obi_if.sv
// req/gnt/rvalid bus bundle for one RAM port (instruction fetch or LSU).
interface dp_ram_obi_if #(
  parameter int unsigned ADDR_WIDTH = 16,
  parameter int unsigned DATA_WIDTH = 32
);
  logic                    req;
  logic                    gnt;
  logic [ADDR_WIDTH-1:0]   addr;
  logic                    we;
  logic [DATA_WIDTH/8-1:0] be;
  logic [DATA_WIDTH-1:0]   wdata;
  logic                    rvalid;
  logic [DATA_WIDTH-1:0]   rdata;

  modport master (output req, addr, we, be, wdata, input gnt, rvalid, rdata);
  modport slave  (input req, addr, we, be, wdata, output gnt, rvalid, rdata);
endinterface

// File: rtl/dp_ram_rsp_pipe.sv
// Response valid/data shift register, READ_LATENCY stages deep.
// Data stages load only behind a valid bit, so rdata holds between responses.
module dp_ram_rsp_pipe #(
  parameter int unsigned READ_LATENCY = 1,
  parameter int unsigned DATA_WIDTH   = 32
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  i_valid,
  input  logic [DATA_WIDTH-1:0] i_data,
  output logic                  o_valid,
  output logic [DATA_WIDTH-1:0] o_data
);

  logic [READ_LATENCY-1:0] r_valid;
  logic [DATA_WIDTH-1:0]   r_data [READ_LATENCY];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_valid <= '0;
      for (int k = 0; k < READ_LATENCY; k++) r_data[k] <= '0;
    end else begin
      r_valid[0] <= i_valid;
      if (i_valid) r_data[0] <= i_data;
      for (int k = 1; k < READ_LATENCY; k++) begin
        r_valid[k] <= r_valid[k-1];
        if (r_valid[k-1]) r_data[k] <= r_data[k-1];
      end
    end
  end

  assign o_valid = r_valid[READ_LATENCY-1];
  assign o_data  = r_data[READ_LATENCY-1];

endmodule

// File: rtl/dp_ram_obi.sv
// Dual-port read-first RAM, port A = instruction fetch, port B = load/store.
// Define RAM_GNT_STALL_EN to insert pseudo-random grant stalls on both ports.
module dp_ram_obi
  import dp_ram_pkg::*;
#(
  parameter int unsigned ADDR_WIDTH   = 16,
  parameter int unsigned DATA_WIDTH   = DEF_DATA_WIDTH,
  parameter int unsigned NUM_WORDS    = 16384,
  parameter int unsigned READ_LATENCY = 1,
  parameter logic [15:0] STALL_SEED_A = 16'hACE1,
  parameter logic [15:0] STALL_SEED_B = 16'h1D2B
) (
  input logic          clk,
  input logic          rst_n,
  dp_ram_obi_if.slave  a,
  dp_ram_obi_if.slave  b
);

  localparam int unsigned NBYTES = DATA_WIDTH / 8;
  localparam int unsigned W_OFFS = $clog2(NBYTES);
  localparam int unsigned IDX_W  = $clog2(NUM_WORDS);

  if (READ_LATENCY < 1 || READ_LATENCY > 4) begin : g_chk_lat
    $error("dp_ram_obi: READ_LATENCY must be 1..4");
  end
  if (DATA_WIDTH < 8 || (DATA_WIDTH & (DATA_WIDTH - 1)) != 0) begin : g_chk_dw
    $error("dp_ram_obi: DATA_WIDTH must be a power of two >= 8");
  end
  if (NUM_WORDS < 2 || (NUM_WORDS & (NUM_WORDS - 1)) != 0 ||
      64'(NUM_WORDS) > (64'd1 << (ADDR_WIDTH - W_OFFS))) begin : g_chk_depth
    $error("dp_ram_obi: NUM_WORDS must be a power of two within the address range");
  end
  if (STALL_SEED_A == 16'h0 || STALL_SEED_B == 16'h0) begin : g_chk_seed
    $error("dp_ram_obi: LFSR seeds must be non-zero");
  end

  logic [DATA_WIDTH-1:0] r_mem [NUM_WORDS];
  logic [IDX_W-1:0]      w_a_idx, w_b_idx;
  logic                  w_a_acc, w_b_acc;
  logic [DATA_WIDTH-1:0] w_a_rdata, w_b_rdata;

  assign w_a_idx = IDX_W'(word_idx(64'(a.addr), W_OFFS, NUM_WORDS));
  assign w_b_idx = IDX_W'(word_idx(64'(b.addr), W_OFFS, NUM_WORDS));

`ifdef RAM_GNT_STALL_EN
  logic [15:0] r_lfsr_a, r_lfsr_b;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_lfsr_a <= STALL_SEED_A;
      r_lfsr_b <= STALL_SEED_B;
    end else begin
      r_lfsr_a <= {r_lfsr_a[14:0], ^(r_lfsr_a & LFSR_TAPS)};
      r_lfsr_b <= {r_lfsr_b[14:0], ^(r_lfsr_b & LFSR_TAPS)};
    end
  end

  assign a.gnt = a.req && (r_lfsr_a[1:0] != 2'b00);
  assign b.gnt = b.req && (r_lfsr_b[1:0] != 2'b00);
`else
  assign a.gnt = a.req;
  assign b.gnt = b.req;
`endif

  assign w_a_acc = a.req && a.gnt;
  assign w_b_acc = b.req && b.gnt;

  // Port B is written second so it owns any byte both ports enable on the same word
  always_ff @(posedge clk) begin
    for (int i = 0; i < NBYTES; i++) begin
      if (w_a_acc && a.we && a.be[i]) r_mem[w_a_idx][8*i +: 8] <= a.wdata[8*i +: 8];
      if (w_b_acc && b.we && b.be[i]) r_mem[w_b_idx][8*i +: 8] <= b.wdata[8*i +: 8];
    end
  end

  // Stage 0 samples the array on the accept edge, before that edge's write lands
  assign w_a_rdata = r_mem[w_a_idx];
  assign w_b_rdata = r_mem[w_b_idx];

  dp_ram_rsp_pipe #(.READ_LATENCY(READ_LATENCY), .DATA_WIDTH(DATA_WIDTH)) u_rsp_a (
    .clk     (clk),
    .rst_n   (rst_n),
    .i_valid (w_a_acc),
    .i_data  (w_a_rdata),
    .o_valid (a.rvalid),
    .o_data  (a.rdata)
  );

  dp_ram_rsp_pipe #(.READ_LATENCY(READ_LATENCY), .DATA_WIDTH(DATA_WIDTH)) u_rsp_b (
    .clk     (clk),
    .rst_n   (rst_n),
    .i_valid (w_b_acc),
    .i_data  (w_b_rdata),
    .o_valid (b.rvalid),
    .o_data  (b.rdata)
  );

endmodule

// File: tb/tb_dp_ram_obi.sv
// Directed bench for dp_ram_obi at READ_LATENCY=3, 1024 words.
// With RAM_GNT_STALL_EN defined it runs the random stall scenario instead.
module tb_dp_ram_obi;
  import dp_ram_pkg::*;

  localparam int unsigned AW  = 16;
  localparam int unsigned DW  = DEF_DATA_WIDTH;
  localparam int unsigned NW  = 1024;
  localparam int unsigned LAT = 3;

  logic clk   = 1'b0;
  logic rst_n = 1'b1;
  int   checks = 0;
  int   errors = 0;

  logic [DW-1:0] ad, bd;
  int            al, bl, an, bn;

  always #5 clk = ~clk;

  dp_ram_obi_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) a_if ();
  dp_ram_obi_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) b_if ();

  dp_ram_obi #(
    .ADDR_WIDTH   (AW),
    .DATA_WIDTH   (DW),
    .NUM_WORDS    (NW),
    .READ_LATENCY (LAT)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .a     (a_if),
    .b     (b_if)
  );

  task automatic idle_a();
    a_if.req = 1'b0; a_if.we = 1'b0; a_if.addr = '0; a_if.be = '0; a_if.wdata = '0;
  endtask

  task automatic idle_b();
    b_if.req = 1'b0; b_if.we = 1'b0; b_if.addr = '0; b_if.be = '0; b_if.wdata = '0;
  endtask

  task automatic drive_a(input logic we, input logic [AW-1:0] addr,
                         input logic [BYTES_PER_WORD-1:0] be, input logic [DW-1:0] wd);
    a_if.req = 1'b1; a_if.we = we; a_if.addr = addr; a_if.be = be; a_if.wdata = wd;
  endtask

  task automatic drive_b(input logic we, input logic [AW-1:0] addr,
                         input logic [BYTES_PER_WORD-1:0] be, input logic [DW-1:0] wd);
    b_if.req = 1'b1; b_if.we = we; b_if.addr = addr; b_if.be = be; b_if.wdata = wd;
  endtask

  task automatic test_reset();
    @(negedge clk); #1;
    checks++;
    if (a_if.rvalid !== 1'b0 || b_if.rvalid !== 1'b0 || a_if.rdata !== '0 || b_if.rdata !== '0) begin
      errors++;
      $display("FAIL reset_outputs: a_rvalid=%b a_rdata=%h b_rvalid=%b b_rdata=%h required all zero",
               a_if.rvalid, a_if.rdata, b_if.rvalid, b_if.rdata);
    end
    a_if.req = 1'b1; b_if.req = 1'b0; #1;
    checks++;
    if (a_if.gnt !== 1'b1 || b_if.gnt !== 1'b0) begin
      errors++;
      $display("FAIL reset_gnt_a: a_gnt=%b b_gnt=%b required 1 0", a_if.gnt, b_if.gnt);
    end
    a_if.req = 1'b0; b_if.req = 1'b1; #1;
    checks++;
    if (a_if.gnt !== 1'b0 || b_if.gnt !== 1'b1) begin
      errors++;
      $display("FAIL reset_gnt_b: a_gnt=%b b_gnt=%b required 0 1", a_if.gnt, b_if.gnt);
    end
    idle_a(); idle_b();
    @(negedge clk); rst_n = 1'b1;
  endtask

`ifdef RAM_GNT_STALL_EN
  task automatic test_stall();
    logic [DW-1:0]             model [16];
    logic [DW-1:0]             expq [$];
    logic [DW-1:0]             e, wd;
    logic [BYTES_PER_WORD-1:0] be;
    logic                      we, have;
    int                        idx, issued, accepts, stalls, rv, cyc;
    have = 1'b0; issued = 0; accepts = 0; stalls = 0; rv = 0; cyc = 0;
    we = 1'b0; be = '0; wd = '0; idx = 0;
    while ((issued < 1000 || expq.size() != 0) && cyc < 10000) begin
      @(negedge clk);
      cyc++;
      if (a_if.rvalid) begin
        rv++;
        checks++;
        if (expq.size() == 0) begin
          errors++;
          $display("FAIL stall_extra_rvalid: rdata=%h with no outstanding transaction", a_if.rdata);
        end else begin
          e = expq.pop_front();
          if (a_if.rdata !== e) begin
            errors++;
            $display("FAIL stall_rdata: got %h required %h", a_if.rdata, e);
          end
        end
      end
      if (issued < 1000) begin
        if (!have) begin
          if (issued < 16) begin
            we = 1'b1; idx = issued; be = '1; wd = $urandom;
          end else begin
            we = 1'($urandom_range(0, 1)); idx = $urandom_range(0, 15);
            be = BYTES_PER_WORD'($urandom_range(0, 15)); wd = $urandom;
          end
          have = 1'b1;
        end
        drive_a(we, AW'(32'h200 + 4 * idx), be, wd);
        #1;
        if (a_if.gnt) begin
          expq.push_back(model[idx]);
          if (we)
            for (int i = 0; i < BYTES_PER_WORD; i++)
              if (be[i]) model[idx][8*i +: 8] = wd[8*i +: 8];
          accepts++; issued++; have = 1'b0;
        end else begin
          stalls++;
        end
      end else begin
        idle_a();
      end
    end
    idle_a();
    checks++;
    if (cyc >= 10000 || accepts != 1000) begin
      errors++;
      $display("FAIL stall_accepts: got %0d accepts in %0d cycles required 1000", accepts, cyc);
    end
    checks++;
    if (rv != accepts || expq.size() != 0) begin
      errors++;
      $display("FAIL stall_rvalid_count: got %0d rvalid required %0d (pending %0d)", rv, accepts, expq.size());
    end
    checks++;
    if (stalls * 100 < 20 * (stalls + accepts) || stalls * 100 > 30 * (stalls + accepts)) begin
      errors++;
      $display("FAIL stall_rate: got %0d stalls of %0d cycles required 20-30%%", stalls, stalls + accepts);
    end
  endtask
`else
  // One cycle with the requested ports asserting req, released right after the accept edge
  task automatic issue(input logic a_en, input logic a_we, input logic [AW-1:0] a_addr,
                       input logic [3:0] a_be, input logic [DW-1:0] a_wd,
                       input logic b_en, input logic b_we, input logic [AW-1:0] b_addr,
                       input logic [3:0] b_be, input logic [DW-1:0] b_wd);
    @(negedge clk);
    if (a_en) drive_a(a_we, a_addr, a_be, a_wd);
    if (b_en) drive_b(b_we, b_addr, b_be, b_wd);
    @(posedge clk); #1;
    idle_a(); idle_b();
  endtask

  // k counts negedges after the accept edge; latency L shows up at k == L
  task automatic collect();
    ad = '0; bd = '0; al = 0; bl = 0; an = 0; bn = 0;
    for (int k = 1; k <= int'(LAT) + 4; k++) begin
      @(negedge clk);
      if (a_if.rvalid) begin
        an++;
        if (al == 0) begin al = k; ad = a_if.rdata; end
      end
      if (b_if.rvalid) begin
        bn++;
        if (bl == 0) begin bl = k; bd = b_if.rdata; end
      end
    end
  endtask

  task automatic test_write_read();
    issue(1'b0, 1'b0, '0, '0, '0, 1'b1, 1'b1, 16'h0010, 4'hF, 32'hDEADBEEF);
    collect();
    checks++;
    if (bl != int'(LAT) || bn != 1 || an != 0) begin
      errors++;
      $display("FAIL write_rvalid: b_lat=%0d b_pulses=%0d a_pulses=%0d required %0d 1 0", bl, bn, an, LAT);
    end
    issue(1'b1, 1'b0, 16'h0010, 4'h0, '0, 1'b0, 1'b0, '0, '0, '0);
    collect();
    checks++;
    if (al != int'(LAT) || an != 1 || bn != 0) begin
      errors++;
      $display("FAIL read_latency: a_lat=%0d a_pulses=%0d b_pulses=%0d required %0d 1 0", al, an, bn, LAT);
    end
    checks++;
    if (ad !== 32'hDEADBEEF) begin
      errors++;
      $display("FAIL read_data: got %h required deadbeef", ad);
    end
  endtask

  task automatic test_partial();
    issue(1'b0, 1'b0, '0, '0, '0, 1'b1, 1'b1, 16'h0020, 4'hF, 32'h11223344);
    collect();
    issue(1'b0, 1'b0, '0, '0, '0, 1'b1, 1'b1, 16'h0020, 4'b0101, 32'hAABBCCDD);
    collect();
    checks++;
    if (bd !== 32'h11223344 || bl != int'(LAT)) begin
      errors++;
      $display("FAIL write_returns_old: got %h lat %0d required 11223344 lat %0d", bd, bl, LAT);
    end
    issue(1'b1, 1'b0, 16'h0020, 4'h0, '0, 1'b0, 1'b0, '0, '0, '0);
    collect();
    checks++;
    if (ad !== 32'h11BB33DD) begin
      errors++;
      $display("FAIL partial_write: got %h required 11bb33dd", ad);
    end
  endtask

  task automatic test_collision();
    issue(1'b0, 1'b0, '0, '0, '0, 1'b1, 1'b1, 16'h0040, 4'hF, 32'h77777777);
    collect();
    issue(1'b1, 1'b1, 16'h0040, 4'hF, 32'h01010101, 1'b1, 1'b1, 16'h0040, 4'b0011, 32'h02020202);
    collect();
    checks++;
    if (al != int'(LAT) || bl != int'(LAT) || an != 1 || bn != 1) begin
      errors++;
      $display("FAIL collision_rvalid: a_lat=%0d b_lat=%0d pulses %0d %0d required %0d %0d 1 1",
               al, bl, an, bn, LAT, LAT);
    end
    checks++;
    if (ad !== 32'h77777777 || bd !== 32'h77777777) begin
      errors++;
      $display("FAIL collision_old_data: a=%h b=%h required 77777777 both", ad, bd);
    end
    issue(1'b1, 1'b0, 16'h0040, 4'h0, '0, 1'b0, 1'b0, '0, '0, '0);
    collect();
    checks++;
    if (ad !== 32'h01010202) begin
      errors++;
      $display("FAIL collision_merge: got %h required 01010202", ad);
    end
  endtask

  task automatic test_read_first_wrap();
    logic [AW-1:0] alias_addr;
    alias_addr = AW'((NW << WORD_OFFS) + 32'h80);
    issue(1'b0, 1'b0, '0, '0, '0, 1'b1, 1'b1, 16'h0080, 4'hF, 32'h00000005);
    collect();
    issue(1'b1, 1'b0, 16'h0080, 4'h0, '0, 1'b1, 1'b1, 16'h0080, 4'hF, 32'h00000009);
    collect();
    checks++;
    if (ad !== 32'h00000005 || bd !== 32'h00000005) begin
      errors++;
      $display("FAIL cross_read_first: a=%h b=%h required 00000005 both", ad, bd);
    end
    issue(1'b1, 1'b0, alias_addr, 4'h0, '0, 1'b0, 1'b0, '0, '0, '0);
    collect();
    checks++;
    if (ad !== 32'h00000009) begin
      errors++;
      $display("FAIL addr_wrap: read %h got %h required 00000009", alias_addr, ad);
    end
  endtask

  task automatic test_back_to_back();
    logic          v [24];
    logic [DW-1:0] d [24];
    logic          exp_v;
    for (int i = 0; i < 8; i++) begin
      issue(1'b0, 1'b0, '0, '0, '0, 1'b1, 1'b1, AW'(32'h100 + 4 * i), 4'hF, 32'hC0DE0000 + i);
    end
    collect();
    for (int k = 0; k < int'(LAT) + 12; k++) begin
      @(negedge clk);
      v[k] = a_if.rvalid; d[k] = a_if.rdata;
      if (k < 8) drive_a(1'b0, AW'(32'h100 + 4 * k), 4'h0, '0);
      else       idle_a();
    end
    for (int k = 0; k < int'(LAT) + 12; k++) begin
      exp_v = (k >= int'(LAT) && k < int'(LAT) + 8);
      checks++;
      if (v[k] !== exp_v) begin
        errors++;
        $display("FAIL stream_rvalid: cycle %0d got %b required %b", k, v[k], exp_v);
      end else if (exp_v && d[k] !== 32'hC0DE0000 + 32'(k - int'(LAT))) begin
        errors++;
        $display("FAIL stream_rdata: cycle %0d got %h required %h", k, d[k], 32'hC0DE0000 + 32'(k - int'(LAT)));
      end
    end
  endtask

  task automatic test_reset_midstream();
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      #1;
      checks++;
      if (a_if.rvalid !== (k == 3) || (k == 3 && a_if.rdata !== 32'hC0DE0000)) begin
        errors++;
        $display("FAIL pre_reset_rvalid: cycle %0d got %b/%h required %b/c0de0000", k, a_if.rvalid, a_if.rdata, k == 3);
      end
      drive_a(1'b0, AW'(32'h100 + 4 * k), 4'h0, '0);
      if (k == 3) drive_b(1'b1, 16'h0180, 4'hF, 32'hFEEDF00D);
    end
    @(negedge clk);
    idle_a(); idle_b();
    rst_n = 1'b0;
    for (int k = 0; k < 3; k++) begin
      #1;
      checks++;
      if (a_if.rvalid !== 1'b0 || b_if.rvalid !== 1'b0 || a_if.rdata !== '0 || b_if.rdata !== '0) begin
        errors++;
        $display("FAIL in_reset_outputs: a=%b/%h b=%b/%h required zero", a_if.rvalid, a_if.rdata, b_if.rvalid, b_if.rdata);
      end
      @(negedge clk);
    end
    rst_n = 1'b1;
    for (int k = 0; k < int'(LAT) + 3; k++) begin
      @(negedge clk);
      checks++;
      if (a_if.rvalid !== 1'b0 || b_if.rvalid !== 1'b0) begin
        errors++;
        $display("FAIL dropped_rvalid: cycle %0d a=%b b=%b required 0 0", k, a_if.rvalid, b_if.rvalid);
      end
    end
    issue(1'b1, 1'b0, 16'h0104, 4'h0, '0, 1'b1, 1'b0, 16'h0180, 4'h0, '0);
    collect();
    checks++;
    if (ad !== 32'hC0DE0001 || bd !== 32'hFEEDF00D) begin
      errors++;
      $display("FAIL mem_after_reset: a=%h b=%h required c0de0001 feedf00d", ad, bd);
    end
  endtask
`endif

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $display("Simulation finished: %0d checks, %0d errors", checks, errors + 1);
    $fatal(1, "timeout");
  end

  initial begin
    idle_a(); idle_b();
    #2 rst_n = 1'b0;
    test_reset();
`ifdef RAM_GNT_STALL_EN
    test_stall();
`else
    test_write_read();
    test_partial();
    test_collision();
    test_read_first_wrap();
    test_back_to_back();
    test_reset_midstream();
`endif
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
